// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Two-digit multiplexed 7-segment display controller.
//
// Holds a CPU-visible VALUE register and a CTRL register. Each is written
// through the io strobe into a shadow copy. The shadow is copied into an
// "active" copy only at a slot boundary, so a digit never shows half of an
// update. Each slot belongs to one digit. A slot is split into 16 PWM
// phases that set the brightness. A short dead time at the start of each
// slot keeps all commons off, so the previous digit does not ghost.
//
// Ports
//   clk      : system clock
//   reset    : synchronous, active-high
//   wr_en    : one-cycle write strobe
//   wr_sel   : 0 = VALUE register, 1 = CTRL register
//   wr_data  : write data (VALUE uses [15:0], CTRL uses [6:0])
//   rd_sel   : readback select, same encoding as wr_sel
//   rd_data  : registered readback of the selected shadow register
//   seg_o    : segments {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACT_LOW
//   com_o    : digit commons, com_o[0] = right digit, polarity set by COM_ACT_LOW
module seg7_scan_ctrl #(
    parameter int PHASE_LEN   = 3906,
    parameter int DEAD_CYC    = 16,
    parameter int BLINK_SLOTS = 1000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit COM_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [31:0] wr_data,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic [7:0]  seg_o,
    output logic [1:0]  com_o
);

    localparam int CYC_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int BLK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(PHASE_LEN - 1);
    localparam logic [CYC_W-1:0] DEAD_LIM  = CYC_W'(DEAD_CYC);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_SLOTS - 1);
    localparam logic [7:0]       SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [1:0]       COM_OFF   = COM_ACT_LOW ? 2'b11 : 2'b00;
    localparam logic [6:0]       CTRL_INIT = 7'h3D;

    logic [15:0]      value_sh, value_act, value_next;
    logic [6:0]       ctrl_sh, ctrl_act, ctrl_next;
    logic [CYC_W-1:0] cyc;
    logic [3:0]       phase;
    logic             digit;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_vis;
    logic             cyc_wrap, slot_end;
    logic             in_dead, digit_on;
    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic [7:0]       pattern;
    logic [1:0]       com_onehot;
    logic [7:0]       seg_next;
    logic [1:0]       com_next;
    logic             unused_wr_bits;

    assign unused_wr_bits = ^wr_data[31:16];

    assign cyc_wrap = (cyc == CYC_LAST);
    assign slot_end = cyc_wrap && (phase == 4'd15);

    // The values the shadows hold after this edge. The active copy also loads
    // from these values, so a write that lands on a slot boundary takes effect
    // in the very next slot.
    assign value_next = (wr_en && !wr_sel) ? wr_data[15:0] : value_sh;
    assign ctrl_next  = (wr_en &&  wr_sel) ? wr_data[6:0]  : ctrl_sh;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            value_sh <= 16'h0000;
            ctrl_sh  <= CTRL_INIT;
        end else begin
            value_sh <= value_next;
            ctrl_sh  <= ctrl_next;
        end
    end

    // Active copies change only at slot boundaries, so a display never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_act <= 16'h0000;
            ctrl_act  <= CTRL_INIT;
        end else if (slot_end) begin
            value_act <= value_next;
            ctrl_act  <= ctrl_next;
        end
    end

    // Scan timing: cycle within phase, phase within slot, digit per slot,
    // and the blink divider, which counts whole slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc       <= '0;
            phase     <= 4'd0;
            digit     <= 1'b0;
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else begin
            cyc <= cyc_wrap ? '0 : cyc + 1'b1;
            if (cyc_wrap)
                phase <= phase + 4'd1;
            if (slot_end) begin
                digit <= ~digit;
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    blink_vis <= ~blink_vis;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_nib    = digit ? value_act[7:4] : value_act[3:0];
        cur_dp     = digit ? value_act[9]   : value_act[8];
        pattern    = ctrl_act[1] ? (digit ? value_act[15:8] : value_act[7:0])
                                 : {cur_dp, hex7(cur_nib)};
        in_dead    = (phase == 4'd0) && (cyc < DEAD_LIM);
        digit_on   = ctrl_act[0] && (phase <= ctrl_act[5:2]) && !in_dead &&
                     (!ctrl_act[6] || blink_vis);
        com_onehot = digit ? 2'b10 : 2'b01;
        seg_next   = digit_on ? (SEG_ACT_LOW ? ~pattern : pattern) : SEG_OFF;
        com_next   = digit_on ? (COM_ACT_LOW ? ~com_onehot : com_onehot) : COM_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_o   <= SEG_OFF;
            com_o   <= COM_OFF;
            rd_data <= 32'h0;
        end else begin
            seg_o   <= seg_next;
            com_o   <= com_next;
            rd_data <= rd_sel ? {25'd0, ctrl_sh} : {16'd0, value_sh};
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Directed, table-driven bench for seg7_scan_ctrl with a short slot.
// The slot is PHASE_LEN=8 cycles times 16 phases, which is 128 cycles.
// t_now counts clock edges since reset release. After edge t, the outputs
// show the scan position g = t-1. Slot s covers edges s*128+1 .. s*128+128.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic [7:0]  seg_o;
    logic [1:0]  com_o;

    int t_now;
    int tests_run;
    int tests_failed;

    typedef struct {
        int          t;
        bit          is_count;
        bit          wr;
        bit          sel;
        logic [31:0] data;
        bit          rsel;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_seg;
        logic [1:0]  exp_com;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[$];

    seg7_scan_ctrl #(
        .PHASE_LEN  (8),
        .DEAD_CYC   (2),
        .BLINK_SLOTS(2),
        .SEG_ACT_LOW(1'b1),
        .COM_ACT_LOW(1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_sel (wr_sel),
        .wr_data(wr_data),
        .rd_sel (rd_sel),
        .rd_data(rd_data),
        .seg_o  (seg_o),
        .com_o  (com_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        t_now++;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] es, input logic [1:0] ec);
        tests_run++;
        if (seg_o !== es || com_o !== ec) begin
            tests_failed++;
            $display("[TB] FAIL %s t=%0d: seg_o=%h com_o=%b, expected seg_o=%h com_o=%b",
                     name, t_now, seg_o, com_o, es, ec);
        end
    endtask

    task automatic checkRead(input string name, input logic [31:0] er);
        tests_run++;
        if (rd_data !== er) begin
            tests_failed++;
            $display("[TB] FAIL %s t=%0d: rd_data=%h, expected %h", name, t_now, rd_data, er);
        end
    endtask

    function automatic vec_t mk(input int t, input logic [7:0] s, input logic [1:0] c);
        vec_t v;
        v.t = t; v.is_count = 1'b0; v.wr = 1'b0; v.sel = 1'b0; v.data = 32'h0;
        v.rsel = 1'b0; v.chk_rd = 1'b0; v.exp_rd = 32'h0;
        v.exp_seg = s; v.exp_com = c; v.exp_cnt = 0;
        return v;
    endfunction

    task automatic addCheck(input int t, input logic [7:0] s, input logic [1:0] c);
        vecs.push_back(mk(t, s, c));
    endtask

    task automatic addWrite(input int t, input bit sel, input logic [31:0] d,
                            input logic [7:0] s, input logic [1:0] c);
        vec_t v = mk(t, s, c);
        v.wr = 1'b1; v.sel = sel; v.data = d;
        vecs.push_back(v);
    endtask

    task automatic addRead(input int t, input bit rsel, input logic [31:0] er,
                           input logic [7:0] s, input logic [1:0] c);
        vec_t v = mk(t, s, c);
        v.rsel = rsel; v.chk_rd = 1'b1; v.exp_rd = er;
        vecs.push_back(v);
    endtask

    task automatic addCount(input int t, input int cnt);
        vec_t v = mk(t, 8'hFF, 2'b11);
        v.is_count = 1'b1; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    // Advance to the edge just before v.t and drive the vector's inputs for
    // that edge. Then either check the outputs or count the active cycles of
    // a whole slot.
    task automatic applyStimulus(input int idx, input vec_t v);
        int active;
        string nm;
        nm = $sformatf("vec%0d", idx);
        while (t_now < v.t - 1) tick();
        wr_en = v.wr; wr_sel = v.sel; wr_data = v.data; rd_sel = v.rsel;
        tick();
        wr_en = 1'b0;
        if (v.is_count) begin
            active = (com_o != 2'b11) ? 1 : 0;
            for (int k = 1; k < 128; k++) begin
                tick();
                if (com_o != 2'b11) active++;
            end
            tests_run++;
            if (active != v.exp_cnt) begin
                tests_failed++;
                $display("[TB] FAIL %s_count: active cycles=%0d, expected %0d", nm, active, v.exp_cnt);
            end
        end else begin
            checkOutput(nm, v.exp_seg, v.exp_com);
            if (v.chk_rd) checkRead({nm, "_rd"}, v.exp_rd);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; t_now = 0;
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = 32'h0; rd_sel = 1'b0;

        // Slots 0-2: power-on "0", then VALUE=0x1A5 shown as "A" and "5."
        addCheck(1,    8'hFF, 2'b11);
        addCheck(2,    8'hFF, 2'b11);
        addCheck(3,    8'hC0, 2'b10);
        addWrite(50,   1'b0, 32'h0000_01A5, 8'hC0, 2'b10);
        addRead (51,   1'b0, 32'h0000_01A5, 8'hC0, 2'b10);
        addCheck(128,  8'hC0, 2'b10);
        addCheck(129,  8'hFF, 2'b11);
        addCheck(131,  8'h88, 2'b01);
        addCheck(259,  8'h12, 2'b10);
        // Brightness 0: only phase 0 after dead time (slot 3 and count in slot 4)
        addWrite(300,  1'b1, 32'h0000_0001, 8'h12, 2'b10);
        addRead (301,  1'b1, 32'h0000_0001, 8'h12, 2'b10);
        addCheck(386,  8'hFF, 2'b11);
        addCheck(387,  8'h88, 2'b01);
        addCheck(392,  8'h88, 2'b01);
        addCheck(393,  8'hFF, 2'b11);
        addCount(513,  6);
        addWrite(650,  1'b1, 32'h0000_003D, 8'hFF, 2'b11);
        addCount(769,  126);
        // Blink from slot 8: lit 8,9, blank 10,11, lit 12
        addWrite(900,  1'b1, 32'h0000_007D, 8'h88, 2'b01);
        addCheck(1089, 8'h12, 2'b10);
        addCheck(1217, 8'h88, 2'b01);
        addCheck(1345, 8'hFF, 2'b11);
        addCheck(1473, 8'hFF, 2'b11);
        addCheck(1601, 8'h12, 2'b10);
        // Raw mode. The VALUE write lands on the slot 12/13 boundary edge.
        addWrite(1650, 1'b1, 32'h0000_003F, 8'h12, 2'b10);
        addWrite(1664, 1'b0, 32'h0000_8001, 8'h12, 2'b10);
        addCheck(1729, 8'h7F, 2'b01);
        addRead (1730, 1'b1, 32'h0000_003F, 8'h7F, 2'b01);
        addRead (1731, 1'b0, 32'h0000_8001, 8'h7F, 2'b01);
        addCheck(1857, 8'hFE, 2'b10);
        // A mid-slot VALUE write must not change the current slot
        addWrite(1870, 1'b0, 32'h0000_0302, 8'hFE, 2'b10);
        addRead (1871, 1'b0, 32'h0000_0302, 8'hFE, 2'b10);
        addCheck(1900, 8'hFE, 2'b10);
        addCheck(1985, 8'hFC, 2'b01);
        // Clear enable: blanks from slot 16 on; re-enable for slot 17
        addWrite(1990, 1'b1, 32'h0000_003E, 8'hFC, 2'b01);
        addCheck(2000, 8'hFC, 2'b01);
        addCheck(2113, 8'hFF, 2'b11);
        addWrite(2120, 1'b1, 32'h0000_003F, 8'hFF, 2'b11);
        addCheck(2241, 8'hFC, 2'b01);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", 8'hFF, 2'b11);
        checkRead("reset_rd", 32'h0);
        reset = 1'b0;
        t_now = 0;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

        // Reset in the middle of phase 9 of a lit slot
        while (t_now < 2249) tick();
        reset = 1'b1; rd_sel = 1'b1;
        tick();
        checkOutput("midreset_out", 8'hFF, 2'b11);
        checkRead("midreset_rd", 32'h0);
        tick();
        reset = 1'b0;
        t_now = 0;
        tick();
        checkOutput("restart_dead", 8'hFF, 2'b11);
        checkRead("restart_ctrl", 32'h0000_003D);
        rd_sel = 1'b0;
        tick();
        checkRead("restart_value", 32'h0);
        tick();
        checkOutput("restart_digit0", 8'hC0, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
